titan_if_stage: RTL and testbench

//  Instruction-fetch stage of the Titan 5-stage pipeline, directly upstream of the ID stage. Owns the PC,

---
 rtl/titan_if_stage_pkg.sv | 22 ++
 rtl/titan_ifid_register.sv | 27 ++
 rtl/titan_if_stage.sv | 146 ++++++++++++++
 tb/tb_titan_if_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/titan_if_stage_pkg.sv
// rtl/titan_if_stage_pkg.sv - shared definitions for the Titan instruction-fetch stage
package titan_if_stage_pkg;

   localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_XCPT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
      logic        misaligned;
      logic        fault;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, instruction: NOP_INSTR, misaligned: 1'b0, fault: 1'b0};

endpackage

// File: rtl/titan_ifid_register.sv
// rtl/titan_ifid_register.sv - IF/ID pipeline register with flush, stall and bubble insertion
module titan_ifid_register
   import titan_if_stage_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  stall,
   input  logic  flush,
   input  logic  load,
   input  ifid_t entry_d,
   output ifid_t entry_q
);

   // Flush beats everything; an unstalled cycle with nothing to deliver becomes a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= IFID_BUBBLE;
      end else if (flush) begin
         entry_q <= IFID_BUBBLE;
      end else if (load) begin
         entry_q <= entry_d;
      end else if (!stall) begin
         entry_q <= IFID_BUBBLE;
      end
   end

endmodule

// File: rtl/titan_if_stage.sv
// rtl/titan_if_stage.sv - Titan fetch stage: PC, Wishbone-classic fetch FSM, redirects, IF/ID feed
module titan_if_stage
   import titan_if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_stall_i,
   input  logic        id_flush_i,
   input  logic        take_branch_i,
   input  logic        take_jump_i,
   input  logic [31:0] pc_branch_address_i,
   input  logic [31:0] pc_jump_address_i,
   input  logic        trap_valid_i,
   input  logic [31:0] trap_address_i,
   output logic [31:0] iport_addr_o,
   output logic        iport_cyc_o,
   output logic        iport_stb_o,
   input  logic [31:0] iport_data_i,
   input  logic        iport_ack_i,
   input  logic        iport_err_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instruction_o,
   output logic        id_inst_addr_misaligned_o,
   output logic        id_inst_access_fault_o
);

   fetch_state_t state_q;
   logic [31:0]  pc_q, pc_next, held_addr_q, buf_data_q, target;
   logic         discard_q, buf_fault_q;
   logic         bus_active, bus_done, fresh_ack, fresh_err;
   logic         redir_jb, redirect, misaligned;
   logic         ifid_load;
   ifid_t        ifid_d, ifid_q;

   // A redirected transfer keeps its original address on the bus until the slave finishes it.
   assign bus_active   = !rst_i && (state_q == ST_FETCH || discard_q);
   assign iport_cyc_o  = bus_active;
   assign iport_stb_o  = bus_active;
   assign iport_addr_o = discard_q ? held_addr_q : pc_q;

   assign bus_done  = bus_active && (iport_ack_i || iport_err_i);
   assign fresh_ack = bus_done && !discard_q && iport_ack_i;
   assign fresh_err = bus_done && !discard_q && !iport_ack_i;

   assign redir_jb   = !id_stall_i && (take_jump_i || take_branch_i) && (state_q != ST_XCPT);
   assign redirect   = trap_valid_i || redir_jb;
   assign target     = trap_valid_i ? trap_address_i :
                       take_jump_i  ? pc_jump_address_i : pc_branch_address_i;
   assign misaligned = redir_jb && !trap_valid_i && (target[1:0] != 2'b00);
   assign pc_next    = pc_q + 32'd4;

   always_comb begin
      ifid_load = 1'b0;
      ifid_d    = '{pc: pc_q, instruction: NOP_INSTR, misaligned: 1'b0, fault: 1'b0};
      if (redirect) begin
         if (misaligned) begin
            ifid_load         = 1'b1;
            ifid_d.pc         = target;
            ifid_d.misaligned = 1'b1;
         end
      end else begin
         case (state_q)
            ST_FETCH: begin
               ifid_load          = (fresh_ack || fresh_err) && !id_stall_i;
               ifid_d.instruction = fresh_ack ? iport_data_i : NOP_INSTR;
               ifid_d.fault       = fresh_err;
            end
            ST_HOLD: begin
               ifid_load          = !id_stall_i;
               ifid_d.instruction = buf_data_q;
               ifid_d.fault       = buf_fault_q;
            end
            default: ifid_load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_ADDR;
         discard_q   <= 1'b0;
         held_addr_q <= 32'h0;
         buf_data_q  <= NOP_INSTR;
         buf_fault_q <= 1'b0;
      end else begin
         if (redirect && bus_active && !(iport_ack_i || iport_err_i)) begin
            discard_q   <= 1'b1;
            held_addr_q <= iport_addr_o;
         end else if (bus_done) begin
            discard_q <= 1'b0;
         end

         if (redirect) begin
            pc_q    <= target;
            state_q <= misaligned ? ST_XCPT : ST_FETCH;
         end else begin
            case (state_q)
               ST_FETCH: begin
                  if (fresh_ack || fresh_err) begin
                     if (id_stall_i) begin
                        buf_data_q  <= fresh_ack ? iport_data_i : NOP_INSTR;
                        buf_fault_q <= fresh_err;
                        state_q     <= ST_HOLD;
                     end else if (fresh_ack) begin
                        pc_q <= pc_next;
                     end else begin
                        state_q <= ST_XCPT;
                     end
                  end
               end
               ST_HOLD: begin
                  if (!id_stall_i) begin
                     if (buf_fault_q) begin
                        state_q <= ST_XCPT;
                     end else begin
                        pc_q    <= pc_next;
                        state_q <= ST_FETCH;
                     end
                  end
               end
               default: state_q <= state_q;
            endcase
         end
      end
   end

   // A trap squashes the IF/ID contents even while decode is stalled.
   titan_ifid_register u_ifid (
      .clk     (clk_i),
      .rst     (rst_i),
      .stall   (id_stall_i),
      .flush   (id_flush_i || trap_valid_i),
      .load    (ifid_load),
      .entry_d (ifid_d),
      .entry_q (ifid_q)
   );

   assign id_pc_o                   = ifid_q.pc;
   assign id_instruction_o          = ifid_q.instruction;
   assign id_inst_addr_misaligned_o = ifid_q.misaligned;
   assign id_inst_access_fault_o    = ifid_q.fault;

endmodule

// File: tb/tb_titan_if_stage.sv
// tb/tb_titan_if_stage.sv - directed table-driven bench for titan_if_stage
module tb_titan_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_i, id_stall_i, id_flush_i, take_branch_i, take_jump_i, trap_valid_i;
   logic [31:0] pc_branch_address_i, pc_jump_address_i, trap_address_i, iport_data_i;
   logic        iport_ack_i, iport_err_i;
   logic [31:0] iport_addr_o, id_pc_o, id_instruction_o;
   logic        iport_cyc_o, iport_stb_o, id_inst_addr_misaligned_o, id_inst_access_fault_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   titan_if_stage #(.RESET_ADDR(32'h8000_0000)) dut (
      .clk_i                     (clk),
      .rst_i                     (rst_i),
      .id_stall_i                (id_stall_i),
      .id_flush_i                (id_flush_i),
      .take_branch_i             (take_branch_i),
      .take_jump_i               (take_jump_i),
      .pc_branch_address_i       (pc_branch_address_i),
      .pc_jump_address_i         (pc_jump_address_i),
      .trap_valid_i              (trap_valid_i),
      .trap_address_i            (trap_address_i),
      .iport_addr_o              (iport_addr_o),
      .iport_cyc_o               (iport_cyc_o),
      .iport_stb_o               (iport_stb_o),
      .iport_data_i              (iport_data_i),
      .iport_ack_i               (iport_ack_i),
      .iport_err_i               (iport_err_i),
      .id_pc_o                   (id_pc_o),
      .id_instruction_o          (id_instruction_o),
      .id_inst_addr_misaligned_o (id_inst_addr_misaligned_o),
      .id_inst_access_fault_o    (id_inst_access_fault_o)
   );

   typedef struct {
      logic        stall, flush, br, jmp, trap, ack, err;
      logic [31:0] data, tgt, btgt;
      logic        exp_cyc;
      logic [31:0] exp_addr, exp_pc, exp_instr;
      logic        exp_mis, exp_flt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", nm, got, exp);
      end
   endtask

   task automatic add(input logic stall, flush, br, jmp, trap, ack, err,
                      input logic [31:0] data, tgt, btgt,
                      input logic cyc, input logic [31:0] addr, pc, instr,
                      input logic mis, flt);
      vec_t v;
      v = '{stall, flush, br, jmp, trap, ack, err, data, tgt, btgt, cyc, addr, pc, instr, mis, flt};
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      id_stall_i          = v.stall;
      id_flush_i          = v.flush;
      take_branch_i       = v.br;
      take_jump_i         = v.jmp;
      trap_valid_i        = v.trap;
      iport_ack_i         = v.ack;
      iport_err_i         = v.err;
      iport_data_i        = v.data;
      pc_jump_address_i   = v.tgt;
      trap_address_i      = v.tgt;
      pc_branch_address_i = v.btgt;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc, instr, input logic mis, flt);
      chk({tag, ".id_pc"}, id_pc_o, pc);
      chk({tag, ".id_instr"}, id_instruction_o, instr);
      chk({tag, ".misaligned"}, {31'b0, id_inst_addr_misaligned_o}, {31'b0, mis});
      chk({tag, ".fault"}, {31'b0, id_inst_access_fault_o}, {31'b0, flt});
   endtask

   initial begin
      vec_t idle;
      idle = '{0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, NOP, 0, 0};

      //  st fl br jp tr ak er data           tgt            btgt           cyc addr           id_pc          instr          mis flt
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0000, 32'h0,         32'h0,         1,  32'h8000_0000, 32'h8000_0000, 32'hD000_0000, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0004, 32'h0,         32'h0,         1,  32'h8000_0004, 32'h8000_0004, 32'hD000_0004, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 32'hD000_0008, 32'h0,         32'h0,         1,  32'h8000_0008, 32'h8000_0004, 32'hD000_0004, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,         32'h0,         0,  32'h0,         32'h8000_0004, 32'hD000_0004, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0,         32'h8000_0008, 32'hD000_0008, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 32'h0,         32'h8000_0100, 32'h0,         1,  32'h8000_000C, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1,  32'h8000_000C, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1,  32'h8000_000C, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 32'h0,         32'h0,         1,  32'h8000_000C, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0100, 32'h0,         32'h0,         1,  32'h8000_0100, 32'h8000_0100, 32'hD000_0100, 0, 0);
      add(0, 0, 0, 1, 0, 1, 0, 32'hD000_0104, 32'h8000_0102, 32'h0,         1,  32'h8000_0104, 32'h8000_0102, NOP,           1, 0);
      add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0,         32'h0,         NOP,           0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 32'h0,         32'h8000_0200, 32'h0,         0,  32'h0,         32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 32'h0,         32'h8000_0008, 32'h0,         0,  32'h0,         32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0008, 32'h0,         32'h0,         1,  32'h8000_0008, 32'h8000_0008, 32'hD000_0008, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_000C, 32'h0,         32'h0,         1,  32'h8000_000C, 32'h8000_000C, 32'hD000_000C, 0, 0);
      add(0, 0, 0, 0, 0, 0, 1, 32'h0,         32'h0,         32'h0,         1,  32'h8000_0010, 32'h8000_0010, NOP,           0, 1);
      add(0, 0, 0, 0, 0, 1, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0,         32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0,  32'h0,         32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 32'h0,         32'h8000_0040, 32'h0,         0,  32'h0,         32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0040, 32'h0,         32'h0,         1,  32'h8000_0040, 32'h8000_0040, 32'hD000_0040, 0, 0);
      add(0, 0, 1, 0, 1, 1, 0, 32'h0BAD_F00D, 32'h8000_0080, 32'h8000_0300, 1,  32'h8000_0044, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0080, 32'h0,         32'h0,         1,  32'h8000_0080, 32'h8000_0080, 32'hD000_0080, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1,  32'h8000_0084, 32'h0,         NOP,           0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         1,  32'h8000_0084, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0084, 32'h0,         32'h0,         1,  32'h8000_0084, 32'h8000_0084, 32'hD000_0084, 0, 0);
      add(0, 0, 1, 0, 0, 1, 0, 32'h0BAD_F00D, 32'h0,         32'h8000_0200, 1,  32'h8000_0088, 32'h0,         NOP,           0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0200, 32'h0,         32'h0,         1,  32'h8000_0200, 32'h8000_0200, 32'hD000_0200, 0, 0);
      add(1, 0, 1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h8000_0300, 1,  32'h8000_0204, 32'h8000_0200, 32'hD000_0200, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 32'hD000_0204, 32'h0,         32'h0,         1,  32'h8000_0204, 32'h8000_0204, 32'hD000_0204, 0, 0);

      // Reset behaviour
      drive(idle);
      rst_i = 1'b1;
      @(negedge clk); #1;
      chk("reset.cyc", {31'b0, iport_cyc_o}, 32'h0);
      @(posedge clk); #1;
      check_ifid("reset", 32'h0, NOP, 1'b0, 1'b0);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      chk("post_reset.cyc", {31'b0, iport_cyc_o}, 32'h1);
      chk("post_reset.stb", {31'b0, iport_stb_o}, 32'h1);
      chk("post_reset.addr", iport_addr_o, 32'h8000_0000);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d.cyc", i), {31'b0, iport_cyc_o}, {31'b0, vecs[i].exp_cyc});
         if (vecs[i].exp_cyc)
            chk($sformatf("v%0d.addr", i), iport_addr_o, vecs[i].exp_addr);
         @(posedge clk); #1;
         check_ifid($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                    vecs[i].exp_mis, vecs[i].exp_flt);
      end

      // PC wrap: trap to the top word, fetch it, next request lands at 0
      @(negedge clk);
      drive(idle);
      trap_valid_i   = 1'b1;
      trap_address_i = 32'hFFFF_FFFC;
      iport_ack_i    = 1'b1;
      iport_data_i   = 32'h0BAD_F00D;
      @(negedge clk);
      drive(idle);
      iport_ack_i  = 1'b1;
      iport_data_i = 32'h0000_1234;
      #1;
      chk("wrap.addr_top", iport_addr_o, 32'hFFFF_FFFC);
      @(posedge clk); #1;
      check_ifid("wrap", 32'hFFFF_FFFC, 32'h0000_1234, 1'b0, 1'b0);
      @(negedge clk);
      drive(idle);
      #1;
      chk("wrap.addr_zero", iport_addr_o, 32'h0000_0000);
      chk("wrap.cyc", {31'b0, iport_cyc_o}, 32'h1);

      // Reset mid-transfer: cyc drops immediately and the ack in the reset cycle is ignored
      @(negedge clk);
      rst_i        = 1'b1;
      iport_ack_i  = 1'b1;
      iport_data_i = 32'h0000_5678;
      #1;
      chk("rst_mid.cyc", {31'b0, iport_cyc_o}, 32'h0);
      @(posedge clk); #1;
      check_ifid("rst_mid", 32'h0, NOP, 1'b0, 1'b0);
      @(negedge clk);
      rst_i       = 1'b0;
      iport_ack_i = 1'b0;
      #1;
      chk("rst_mid.restart_cyc", {31'b0, iport_cyc_o}, 32'h1);
      chk("rst_mid.restart_addr", iport_addr_o, 32'h8000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
